mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates one synchronous single-port RAM (block-RAM IP, registered read) between two requesters:
  - the CPU datapath's MAR/MBR port (CPU port);
  - the debug/program-loader port (DBG port).
- Each requester uses a req/ack handshake. The block sequences issue, read-latency wait and completion, and holds returned data stable for the requester.
- Sits between the CPU, the loader and the main memory.

Parameters:
- ADDR_W, 8, address width of both ports and the RAM.
- DATA_W, 16, data width.
- RD_LAT, 1, RAM read latency in cycles; legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  last CPU read result.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  DBG equivalents of the CPU inputs.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DATA_W  last DBG read result.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after mem_en.
- cpu_gnt  out  1  CPU owns the RAM (ISSUE through DONE).
- dbg_gnt  out  1  DBG owns the RAM (ISSUE through DONE).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst high at an edge):
  - state = IDLE, last_owner = DBG, wait counter = 0;
  - all outputs 0, including cpu_rdata and dbg_rdata.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Both req low: stay in IDLE.
  - One req high: grant that requester.
  - Both req high: grant the port that is not last_owner (round-robin), so the CPU wins the first tie after reset.
  - On grant: latch owner, we, addr and wdata into internal registers; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en = 1; mem_we, mem_addr and mem_wdata come from the latched registers.
  - Next state: DONE if write; WAIT if read, with counter loaded to RD_LAT-1.
- WAIT (exactly RD_LAT cycles):
  - mem_en = 0.
  - The counter decrements each cycle.
  - On the last WAIT cycle, capture mem_rdata into the owner's rdata register, then go to DONE.
- DONE (exactly 1 cycle):
  - The owner's ack = 1.
  - last_owner is updated to the owner.
  - Next state is IDLE.
- Latency, req sampled high in IDLE at cycle T:
  - write: ack during T+2;
  - read: ack during T+2+RD_LAT, with rdata valid in the same cycle.
- Requester rule: drop req in the cycle after seeing ack. A req still high in the following IDLE cycle is treated as a new access.
- Latched-input rule: inputs are latched at grant. Changes to addr, wdata or we after grant have no effect on the access in flight.
- The non-owner's req is ignored until IDLE; it is never dropped, only delayed (at most one full access).
- rdata registers hold their value until the same port's next read completes. Writes and the other port's accesses never alter them.
- mem_en, mem_we, mem_addr and mem_wdata are 0 outside ISSUE.
- cpu_gnt/dbg_gnt are high from ISSUE through DONE for the owner.
- Reset mid-operation:
  - If rst is high during ISSUE, the RAM still samples that cycle's write. No ack is produced, and rdata is not updated.
  - If rst is high during WAIT or DONE, the access is abandoned: no ack, rdata is cleared.
- Simultaneous new req in DONE: sampled only in the next IDLE cycle, so there is one idle cycle minimum between accesses.
- Address wrap: none; addresses pass through unchanged at full width.

Test Plan:
- CPU write 0x1234 to 0x05, no DBG activity -> mem_en=1, mem_we=1, addr=0x05, wdata=0x1234 in cycle T+1; cpu_ack in T+2; cpu_rdata stays 0.
- RAM preloaded with [0x05]=0x1234; CPU read 0x05 with RD_LAT=1 -> cpu_ack and cpu_rdata=0x1234 in T+3; dbg_ack stays 0.
- cpu_req and dbg_req both high right after reset, both writes -> CPU served first (ack T+2), DBG next (issue T+4, ack T+5). Repeat the tie -> CPU first again, since last_owner=DBG after the second access.
- DBG read of 0x10 (data 0xBEEF) in flight; CPU changes cpu_addr each cycle while holding req -> dbg_rdata=0xBEEF; the CPU access uses the addr present in the IDLE cycle it is granted.
- rst pulsed during WAIT of a CPU read -> no cpu_ack, cpu_rdata=0, busy=0 next cycle; a following CPU read completes normally.
- RD_LAT=3, DBG read -> dbg_ack exactly 5 cycles after the sampling cycle T; mem_en high only in T+1.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port RAM (registered read) between the
// CPU MAR/MBR port and the debug/program-loader port.
//
// Each access runs IDLE -> ISSUE -> (WAIT x RD_LAT, reads only) -> DONE -> IDLE.
// Requests are latched at grant, so a requester may change its inputs freely once
// granted. Ties in IDLE go to the port that did not own the previous access.
// Read results land in per-port registers and stay there until that same port's
// next read completes.
//
// RD_LAT is the RAM read latency in cycles; the legal range is 1..3.

module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    // CPU port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    // Debug / loader port
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,

    // RAM side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    // Status
    output logic              cpu_gnt,
    output logic              dbg_gnt,
    output logic              busy
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Owner encoding
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    // WAIT lasts RD_LAT cycles: load RD_LAT-1 and leave when the counter reads zero.
    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic              owner_q;
    logic              last_owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        cnt_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    logic              grant;
    logic              grant_owner;
    logic              in_issue;
    logic              in_done;
    logic              capture;

    assign in_issue = (state_q == ST_ISSUE);
    assign in_done  = (state_q == ST_DONE);
    // Last WAIT cycle: mem_rdata carries the read result for the issued address.
    assign capture  = (state_q == ST_WAIT) && (cnt_q == 2'd0);

    // Next-state and grant decision
    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        grant_owner = OWN_CPU;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req || dbg_req) begin
                    grant   = 1'b1;
                    state_d = ST_ISSUE;
                    if (cpu_req && dbg_req) begin
                        // Round-robin on a tie: the port that waited last time wins.
                        grant_owner = ~last_owner_q;
                    end else if (dbg_req) begin
                        grant_owner = OWN_DBG;
                    end else begin
                        grant_owner = OWN_CPU;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = we_q ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // New requests are only looked at in IDLE, which forces one idle cycle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the winning request at grant so later input changes cannot disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            owner_q <= grant_owner;
            if (grant_owner == OWN_DBG) begin
                we_q    <= dbg_we;
                addr_q  <= dbg_addr;
                wdata_q <= dbg_wdata;
            end else begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
            end
        end
    end

    // Read-latency counter: loaded in ISSUE, counts down through WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else if (in_issue) begin
            cnt_q <= WAIT_INIT;
        end else if ((state_q == ST_WAIT) && (cnt_q != 2'd0)) begin
            cnt_q <= cnt_q - 2'd1;
        end
    end

    // Round-robin history, updated when an access completes
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= OWN_DBG;
        end else if (in_done) begin
            last_owner_q <= owner_q;
        end
    end

    // Per-port read-data holding registers; only the owner's own reads update them
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else if (capture) begin
            if (owner_q == OWN_DBG) begin
                dbg_rdata_q <= mem_rdata;
            end else begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

    // Output decode from the registered state
    always_comb begin
        // RAM strobes only in ISSUE; a reset in ISSUE still lets the RAM see the write.
        mem_en    = in_issue;
        mem_we    = in_issue & we_q;
        mem_addr  = in_issue ? addr_q : '0;
        mem_wdata = in_issue ? wdata_q : '0;

        // A reset arriving in DONE abandons the access, so the ack is suppressed.
        cpu_ack   = in_done && (owner_q == OWN_CPU) && !rst;
        dbg_ack   = in_done && (owner_q == OWN_DBG) && !rst;

        busy      = (state_q != ST_IDLE);
        cpu_gnt   = busy && (owner_q == OWN_CPU);
        dbg_gnt   = busy && (owner_q == OWN_DBG);

        cpu_rdata = cpu_rdata_q;
        dbg_rdata = dbg_rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written multi-cycle sequences,
// and randomized traffic checked every cycle against a transaction-level model.
// A second instance with RD_LAT=3 covers the longer read latency.

module tb_mem_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int LAT1 = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // RAM contents before any write
    function automatic logic [DW-1:0] pre(input int i);
        return 16'(i * 3 + 16'h0100);
    endfunction

    // ---------------- DUT with RD_LAT = 1 ----------------
    logic          init;
    logic          rst;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic          cpu_ack, dbg_ack, cpu_gnt, dbg_gnt, busy;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT1)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt), .busy(busy)
    );

    // RAM stub, one-cycle registered read
    logic [DW-1:0] ram1 [256];
    logic [DW-1:0] rd1_q;
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 256; i++) ram1[i] <= pre(i);
            rd1_q <= '0;
        end else if (mem_en) begin
            if (mem_we) ram1[mem_addr] <= mem_wdata;
            else        rd1_q <= ram1[mem_addr];
        end
    end
    assign mem_rdata = rd1_q;

    // ---------------- DUT with RD_LAT = 3 ----------------
    logic          rst3;
    logic          cpu_req3, cpu_we3, dbg_req3, dbg_we3;
    logic [AW-1:0] cpu_addr3, dbg_addr3;
    logic [DW-1:0] cpu_wdata3, dbg_wdata3;
    logic          cpu_ack3, dbg_ack3, cpu_gnt3, dbg_gnt3, busy3;
    logic [DW-1:0] cpu_rdata3, dbg_rdata3;
    logic          mem_en3, mem_we3;
    logic [AW-1:0] mem_addr3;
    logic [DW-1:0] mem_wdata3, mem_rdata3;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT3)) u_dut3 (
        .clk(clk), .rst(rst3),
        .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
        .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
        .dbg_req(dbg_req3), .dbg_we(dbg_we3), .dbg_addr(dbg_addr3), .dbg_wdata(dbg_wdata3),
        .dbg_ack(dbg_ack3), .dbg_rdata(dbg_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3),
        .cpu_gnt(cpu_gnt3), .dbg_gnt(dbg_gnt3), .busy(busy3)
    );

    // RAM stub, three-cycle read pipeline
    logic [DW-1:0] ram3 [256];
    logic [DW-1:0] pipe3 [3];
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 256; i++) ram3[i] <= pre(i);
            pipe3[0] <= '0;
            pipe3[1] <= '0;
            pipe3[2] <= '0;
        end else begin
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
            if (mem_en3) begin
                if (mem_we3) ram3[mem_addr3] <= mem_wdata3;
                else         pipe3[0] <= ram3[mem_addr3];
            end
        end
    end
    assign mem_rdata3 = pipe3[2];

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: an access lasts 2 cycles (write) or 2+RD_LAT (read)
    // after the grant cycle; RAM strobes on the first, ack on the last.
    task automatic monitor();
        logic [DW-1:0] mm [256];
        logic [DW-1:0] rdv [2];
        bit            act, own, last, en, done;
        int            k, len;
        logic          we_l;
        logic [AW-1:0] a_l;
        logic [DW-1:0] wd_l;
        for (int i = 0; i < 256; i++) mm[i] = pre(i);
        act = 0; own = 0; last = 1; k = 0; len = 0;
        we_l = 0; a_l = '0; wd_l = '0; rdv[0] = '0; rdv[1] = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            en   = act && (k == 1);
            done = act && (k == len);
            if (done && !we_l) rdv[own] = mm[a_l];
            chk("mon_cpu_ack", cpu_ack, done && !own && !rst);
            chk("mon_dbg_ack", dbg_ack, done && own && !rst);
            chk("mon_cpu_gnt", cpu_gnt, act && !own);
            chk("mon_dbg_gnt", dbg_gnt, act && own);
            chk("mon_busy", busy, act);
            chk("mon_mem_en", mem_en, en);
            chk("mon_mem_we", mem_we, en && we_l);
            chk("mon_mem_addr", mem_addr, en ? a_l : '0);
            chk("mon_mem_wdata", mem_wdata, en ? wd_l : '0);
            chk("mon_cpu_rdata", cpu_rdata, rdv[0]);
            chk("mon_dbg_rdata", dbg_rdata, rdv[1]);
            if (en && we_l) mm[a_l] = wd_l;
            if (rst) begin
                act = 0; last = 1; rdv[0] = '0; rdv[1] = '0;
            end else if (act) begin
                if (done) begin act = 0; last = own; end
                else k++;
            end else if (cpu_req || dbg_req) begin
                own  = (cpu_req && dbg_req) ? !last : dbg_req;
                we_l = own ? dbg_we : cpu_we;
                a_l  = own ? dbg_addr : cpu_addr;
                wd_l = own ? dbg_wdata : cpu_wdata;
                act  = 1; k = 1;
                len  = we_l ? 2 : 2 + LAT1;
            end
        end
    endtask

    typedef struct {
        bit            port;   // 0 = CPU, 1 = DBG
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        int            lat;    // cycles from sampling cycle to ack
        logic [DW-1:0] rd;     // owner's rdata during the ack cycle
    } vec_t;

    // One access on the RD_LAT=1 instance, starting at posedge+1 with the arbiter idle
    task automatic run_vec(input vec_t v);
        int lat, issue, en_cnt, other;
        logic [AW-1:0] o_addr;
        logic o_we;
        logic [DW-1:0] o_wd, o_rd;
        lat = -1; issue = -1; en_cnt = 0; other = 0;
        o_addr = 'x; o_we = 1'bx; o_wd = 'x; o_rd = 'x;
        if (v.port) begin
            dbg_req = 1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wd;
        end else begin
            cpu_req = 1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wd;
        end
        for (int c = 0; c < 12 && lat < 0; c++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cnt++; issue = c; o_addr = mem_addr; o_we = mem_we; o_wd = mem_wdata;
            end
            if (v.port ? cpu_ack : dbg_ack) other++;
            if (v.port ? dbg_ack : cpu_ack) begin
                lat = c; o_rd = v.port ? dbg_rdata : cpu_rdata;
            end
            @(posedge clk); #1;
        end
        cpu_req = 0; dbg_req = 0;
        @(posedge clk); #1;
        chk("vec_latency", lat, v.lat);
        chk("vec_issue_cycle", issue, 1);
        chk("vec_en_count", en_cnt, 1);
        chk("vec_other_ack", other, 0);
        chk("vec_mem_addr", o_addr, v.addr);
        chk("vec_mem_we", o_we, v.we);
        chk("vec_mem_wdata", o_wd, v.wd);
        chk("vec_rdata", o_rd, v.rd);
    endtask

    // One DBG access on the RD_LAT=3 instance
    task automatic d3_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input int exp_ack, input logic [DW-1:0] exp_rd);
        int ackc, en_first, en_cnt;
        logic [DW-1:0] rd;
        ackc = -1; en_first = -1; en_cnt = 0; rd = 'x;
        dbg_req3 = 1; dbg_we3 = we; dbg_addr3 = a; dbg_wdata3 = wd;
        for (int c = 0; c < 10 && ackc < 0; c++) begin
            @(negedge clk);
            if (mem_en3) begin
                en_cnt++;
                if (en_first < 0) en_first = c;
            end
            if (dbg_ack3) begin ackc = c; rd = dbg_rdata3; end
            @(posedge clk); #1;
        end
        dbg_req3 = 0;
        @(posedge clk); #1;
        chk("lat3_ack_cycle", ackc, exp_ack);
        chk("lat3_en_cycle", en_first, 1);
        chk("lat3_en_count", en_cnt, 1);
        chk("lat3_rdata", rd, exp_rd);
    endtask

    initial begin
        vec_t tbl [8];
        vec_t v;
        int ci, ck, di, dk, cacks;
        bit ca, da;
        logic [AW-1:0] hist [16];

        tbl[0] = '{0, 1, 8'h05, 16'h1234, 2, 16'h0000};
        tbl[1] = '{0, 0, 8'h05, 16'h0000, 3, 16'h1234};
        tbl[2] = '{1, 1, 8'h10, 16'hBEEF, 2, 16'h0000};
        tbl[3] = '{1, 0, 8'h10, 16'h0000, 3, 16'hBEEF};
        tbl[4] = '{0, 1, 8'hFF, 16'hA5A5, 2, 16'h1234};
        tbl[5] = '{0, 0, 8'hFF, 16'h5A5A, 3, 16'hA5A5};
        tbl[6] = '{1, 0, 8'h00, 16'h0000, 3, 16'h0100};
        tbl[7] = '{0, 0, 8'h80, 16'h0000, 3, 16'h0280};

        init = 1; rst = 1; rst3 = 1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        cpu_req3 = 0; cpu_we3 = 0; cpu_addr3 = '0; cpu_wdata3 = '0;
        dbg_req3 = 0; dbg_we3 = 0; dbg_addr3 = '0; dbg_wdata3 = '0;
        fork
            monitor();
        join_none
        @(posedge clk); #1;
        init = 0;
        @(posedge clk); #1;
        rst = 0; rst3 = 0;

        // Directed single-port accesses
        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Reset during WAIT of a CPU read abandons it and clears cpu_rdata
        chk("rstw_pre_rdata", cpu_rdata, 16'h0280);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05; cpu_wdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; cpu_req = 0;
        @(posedge clk); #1;
        rst = 0;
        cacks = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (cpu_ack) cacks++;
            if (k == 0) begin
                chk("rstw_busy", busy, 1'b0);
                chk("rstw_rdata", cpu_rdata, 16'h0000);
            end
            @(posedge clk); #1;
        end
        chk("rstw_no_ack", cacks, 0);
        v = '{0, 0, 8'h05, 16'h0000, 3, 16'h1234};
        run_vec(v);

        // Tie right after reset, twice: CPU wins both times
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int rep = 0; rep < 2; rep++) begin
            cpu_req = 1; cpu_we = 1; cpu_addr = 8'(8'h20 + rep); cpu_wdata = 16'h1111;
            dbg_req = 1; dbg_we = 1; dbg_addr = 8'(8'h28 + rep); dbg_wdata = 16'h2222;
            ci = -1; ck = -1; di = -1; dk = -1;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (mem_en && cpu_gnt) ci = c;
                if (mem_en && dbg_gnt) di = c;
                ca = cpu_ack; da = dbg_ack;
                if (ca) ck = c;
                if (da) dk = c;
                @(posedge clk); #1;
                if (ca) cpu_req = 0;
                if (da) dbg_req = 0;
            end
            cpu_req = 0; dbg_req = 0;
            chk("tie_cpu_issue", ci, 1);
            chk("tie_cpu_ack", ck, 2);
            chk("tie_dbg_issue", di, 4);
            chk("tie_dbg_ack", dk, 5);
        end

        // DBG read in flight while the CPU waits with a wandering address
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h10; dbg_wdata = '0;
        ci = -1; dk = -1;
        for (int c = 0; c < 12; c++) begin
            hist[c] = cpu_addr;
            @(negedge clk);
            if (mem_en && cpu_gnt) begin
                ci = c;
                if (c > 0) chk("wander_cpu_addr", mem_addr, hist[c-1]);
            end
            if (dbg_ack) begin
                dk = c;
                chk("wander_dbg_rdata", dbg_rdata, 16'hBEEF);
            end
            ca = cpu_ack; da = dbg_ack;
            @(posedge clk); #1;
            if (da) dbg_req = 0;
            if (ca) cpu_req = 0;
            else if (c == 0) begin cpu_req = 1; cpu_we = 0; cpu_addr = 8'($urandom); end
            else if (cpu_req) cpu_addr = 8'($urandom);
        end
        cpu_req = 0; dbg_req = 0;
        chk("wander_dbg_ack", dk, 3);
        chk("wander_cpu_issue", ci, 5);

        // RD_LAT = 3 instance
        d3_access(0, 8'h33, 16'h0000, 5, 16'h0199);
        d3_access(1, 8'h40, 16'h7777, 2, 16'h0199);
        d3_access(0, 8'h40, 16'h0000, 5, 16'h7777);

        // Random traffic with occasional resets; the monitor does the checking
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            ca = cpu_ack; da = dbg_ack;
            @(posedge clk); #1;
            rst = ($urandom_range(127) == 0);
            if (cpu_req && ca) cpu_req = 0;
            else if (!cpu_req && $urandom_range(3) == 0) begin
                cpu_req = 1; cpu_we = $urandom_range(1) == 1;
                cpu_addr = 8'($urandom); cpu_wdata = 16'($urandom);
            end else if (cpu_req && $urandom_range(1) == 0) begin
                cpu_we = $urandom_range(1) == 1;
                cpu_addr = 8'($urandom); cpu_wdata = 16'($urandom);
            end
            if (dbg_req && da) dbg_req = 0;
            else if (!dbg_req && $urandom_range(3) == 0) begin
                dbg_req = 1; dbg_we = $urandom_range(1) == 1;
                dbg_addr = 8'($urandom); dbg_wdata = 16'($urandom);
            end else if (dbg_req && $urandom_range(1) == 0) begin
                dbg_we = $urandom_range(1) == 1;
                dbg_addr = 8'($urandom); dbg_wdata = 16'($urandom);
            end
        end

        // Drain outstanding requests without starting new ones
        rst = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            ca = cpu_ack; da = dbg_ack;
            @(posedge clk); #1;
            if (ca) cpu_req = 0;
            if (da) dbg_req = 0;
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
